cache_axi_master: RTL and testbench
===================================

CACHE_AXI_MASTER -- requirements
Module: cache_axi_master
Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32: cache and AXI address width.
REQ-002 SHALL have parameter DATA_SIZE, default 32: word and AXI data width; each AXI beat is one word.
REQ-003 SHALL have parameter BLOCK_SIZE, default 6: BEATS = 1<<BLOCK_SIZE words per line (64).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port addr_valid_out  input  1  cache memory request valid.
REQ-007 SHALL have port addr_out_m  input  ADDR_SIZE  cache request line address.
REQ-008 SHALL have port rw_out  input  1  request type: 1 = write-back, 0 = line load.
REQ-009 SHALL have port valid_wb  input  1  cache write-back line valid.
REQ-010 SHALL have port data_out_m  input  BEATS x DATA_SIZE  write-back line, word 0 first beat.
REQ-011 SHALL have port ready_wb  output  1  one-cycle pulse: write-back line captured.
REQ-012 SHALL have port valid_ld  output  1  load line valid toward cache.
REQ-013 SHALL have port data_in_m  output  BEATS x DATA_SIZE  load line buffer, word i = beat i.
REQ-014 SHALL have port ready_ld  input  1  cache accepts load line.
REQ-015 SHALL have port bus_err  output  1  sticky: any non-OKAY BRESP/RRESP seen since reset.
REQ-016 SHALL have port awaddr  output  ADDR_SIZE  write burst address.
REQ-017 SHALL have ports awlen(8)/awsize(3)/awburst(2)/wstrb(DATA_SIZE/8), all outputs, constants BEATS-1 / log2(DATA_SIZE/8) / INCR(01) / all ones; arlen/arsize/arburst identical on the read channel.
REQ-018 SHALL have port awvalid  output  1  AW valid.
REQ-019 SHALL have port awready  input  1  AW ready.
REQ-020 SHALL have port wdata  output  DATA_SIZE  write beat data.
REQ-021 SHALL have port wlast  output  1  high on beat BEATS-1 only.
REQ-022 SHALL have port wvalid  output  1  W valid.
REQ-023 SHALL have port wready  input  1  W ready.
REQ-024 SHALL have port bresp  input  2  write response.
REQ-025 SHALL have port bvalid  input  1  B valid.
REQ-026 SHALL have port bready  output  1  B ready.
REQ-027 SHALL have port araddr  output  ADDR_SIZE  read burst address.
REQ-028 SHALL have port arvalid  output  1  AR valid.
REQ-029 SHALL have port arready  input  1  AR ready.
REQ-030 SHALL have port rdata  input  DATA_SIZE  read beat data.
REQ-031 SHALL have port rresp  input  2  read response.
REQ-032 SHALL have port rlast  input  1  read last beat (informational).
REQ-033 SHALL have port rvalid  input  1  R valid.
REQ-034 SHALL have port rready  output  1  R ready.
Function
REQ-035 SHALL implement FSM IDLE, WB_CAP, AW, W, B, AR, R, LD; one outstanding transaction; no AXI IDs.
REQ-036 SHALL in IDLE on addr_valid_out latch addr_out_m with low BLOCK_SIZE bits cleared into awaddr/araddr; rw_out=1 -> WB_CAP, rw_out=0 -> AR; addr_valid_out ignored outside IDLE.
REQ-037 SHALL in WB_CAP on valid_wb capture data_out_m into line buffer, pulse ready_wb one cycle, go AW; wait indefinitely otherwise.
REQ-038 SHALL hold awvalid/arvalid high with stable address until ready sampled high (AW->W, AR->R); no valid depends combinationally on ready.
REQ-039 SHALL in W drive wvalid=1, wdata=buffer[beat]; beat counter (BLOCK_SIZE bits) advances only on wvalid&wready; after beat BEATS-1 accepted go B; wvalid never drops mid-burst.
REQ-040 SHALL in B hold bready=1; on bvalid go IDLE, set bus_err if bresp!=00.
REQ-041 SHALL in R hold rready=1; on rvalid store rdata into buffer[beat], OR rresp!=00 into bus_err; completion by count (beat BEATS-1), rlast ignored; then LD.
REQ-042 SHALL in LD hold valid_ld=1 and data_in_m stable until ready_ld high, then IDLE next cycle; back-to-back requests accepted from IDLE the cycle after.
Reset
REQ-043 SHALL on rst_n low, asynchronously and even mid-burst: FSM IDLE, beat=0, bus_err=0, all valid/ready/last outputs 0, addresses 0, buffer undefined-free (cleared to 0).
Verification
REQ-044 Load, addr 0x0000_1234, arready=1, rvalid every cycle rdata=beat index -> araddr=0x0000_1200, arlen=63, 64 beats, valid_ld with word i = i.
REQ-045 Write-back, line word i = 0xA000_0000+i, wready toggling 1/0 -> 64 W beats in order, wlast on beat 63 only, ready_wb one pulse, bready until bvalid.
REQ-046 arready held low 10 cycles -> arvalid/araddr stable all 10 cycles, no R accept before handshake.
REQ-047 rresp=10 on beat 5 -> load still completes, bus_err=1 and stays 1 through next clean transaction.
REQ-048 rst_n low at W beat 20 -> all outputs 0 asynchronously; after release new load request runs from beat 0.

Source files
------------

// File: rtl/cache_axi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_axi_master : one-line-at-a-time AXI4 burst master for a cache       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module cache_axi_master #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  addr_valid_out,
  input  logic [ADDR_SIZE-1:0]                  addr_out_m,
  input  logic                                  rw_out,
  input  logic                                  valid_wb,
  input  logic [(DATA_SIZE<<BLOCK_SIZE)-1:0]    data_out_m,
  output logic                                  ready_wb,
  output logic                                  valid_ld,
  output logic [(DATA_SIZE<<BLOCK_SIZE)-1:0]    data_in_m,
  input  logic                                  ready_ld,
  output logic                                  bus_err,
  output logic [ADDR_SIZE-1:0]                  awaddr,
  output logic [7:0]                            awlen,
  output logic [2:0]                            awsize,
  output logic [1:0]                            awburst,
  output logic                                  awvalid,
  input  logic                                  awready,
  output logic [DATA_SIZE-1:0]                  wdata,
  output logic [DATA_SIZE/8-1:0]                wstrb,
  output logic                                  wlast,
  output logic                                  wvalid,
  input  logic                                  wready,
  input  logic [1:0]                            bresp,
  input  logic                                  bvalid,
  output logic                                  bready,
  output logic [ADDR_SIZE-1:0]                  araddr,
  output logic [7:0]                            arlen,
  output logic [2:0]                            arsize,
  output logic [1:0]                            arburst,
  output logic                                  arvalid,
  input  logic                                  arready,
  input  logic [DATA_SIZE-1:0]                  rdata,
  input  logic [1:0]                            rresp,
  input  logic                                  rlast,
  input  logic                                  rvalid,
  output logic                                  rready
);

  localparam int BEATS = 1 << BLOCK_SIZE;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WB_CAP = 3'd1;
  localparam logic [2:0] ST_AW     = 3'd2;
  localparam logic [2:0] ST_W      = 3'd3;
  localparam logic [2:0] ST_B      = 3'd4;
  localparam logic [2:0] ST_AR     = 3'd5;
  localparam logic [2:0] ST_R      = 3'd6;
  localparam logic [2:0] ST_LD     = 3'd7;

  localparam logic [BLOCK_SIZE-1:0] LAST_BEAT = '1;
  localparam logic [ADDR_SIZE-1:0]  ADDR_MASK =
    {{(ADDR_SIZE-BLOCK_SIZE){1'b1}}, {BLOCK_SIZE{1'b0}}};
  localparam logic [7:0] AXLEN  = 8'(BEATS - 1);
  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_SIZE/8));

  logic [2:0]            state_q, state_d;
  logic [BLOCK_SIZE-1:0] beat_q, beat_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic                  err_q, err_d;
  logic [DATA_SIZE-1:0]  buf_q [BEATS];

  // Completion is counted locally, so the last-beat flag from the slave is not needed.
  logic w_unused_rlast;
  assign w_unused_rlast = rlast;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (addr_valid_out) begin
          addr_d  = addr_out_m & ADDR_MASK;
          state_d = rw_out ? ST_WB_CAP : ST_AR;
        end
      end
      ST_WB_CAP: if (valid_wb) state_d = ST_AW;
      ST_AW:     if (awready) state_d = ST_W;
      ST_W: begin
        if (wready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_B;
        end
      end
      ST_B: begin
        if (bvalid) begin
          state_d = ST_IDLE;
          if (bresp != 2'b00) err_d = 1'b1;
        end
      end
      ST_AR:     if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid) begin
          beat_d = beat_q + 1'b1;
          if (rresp != 2'b00) err_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_LD;
        end
      end
      ST_LD:     if (ready_ld) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // The line buffer is shared: filled whole by a write-back capture or beat by beat by a read burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
    end else if (state_q == ST_WB_CAP && valid_wb) begin
      for (int i = 0; i < BEATS; i++) buf_q[i] <= data_out_m[i*DATA_SIZE +: DATA_SIZE];
    end else if (state_q == ST_R && rvalid) begin
      buf_q[beat_q] <= rdata;
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_flat
    assign data_in_m[gi*DATA_SIZE +: DATA_SIZE] = buf_q[gi];
  end

  assign ready_wb = (state_q == ST_WB_CAP) && valid_wb;
  assign valid_ld = (state_q == ST_LD);
  assign bus_err  = err_q;

  assign awaddr  = addr_q;
  assign awlen   = AXLEN;
  assign awsize  = AXSIZE;
  assign awburst = 2'b01;
  assign awvalid = (state_q == ST_AW);

  assign wdata  = buf_q[beat_q];
  assign wstrb  = '1;
  assign wvalid = (state_q == ST_W);
  assign wlast  = (state_q == ST_W) && (beat_q == LAST_BEAT);
  assign bready = (state_q == ST_B);

  assign araddr  = addr_q;
  assign arlen   = AXLEN;
  assign arsize  = AXSIZE;
  assign arburst = 2'b01;
  assign arvalid = (state_q == ST_AR);
  assign rready  = (state_q == ST_R);

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_axi_master : directed/random bench with behavioural AXI slave    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_cache_axi_master;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BS    = 6;
  localparam int BEATS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic addr_valid_out, rw_out, valid_wb, ready_wb, valid_ld, ready_ld, bus_err;
  logic [AW-1:0] addr_out_m, awaddr, araddr;
  logic [DW*BEATS-1:0] data_out_m, data_in_m;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  always #5 clk = ~clk;

  cache_axi_master #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_valid_out(addr_valid_out), .addr_out_m(addr_out_m), .rw_out(rw_out),
    .valid_wb(valid_wb), .data_out_m(data_out_m), .ready_wb(ready_wb),
    .valid_ld(valid_ld), .data_in_m(data_in_m), .ready_ld(ready_ld), .bus_err(bus_err),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_model = 1'b0;
  logic [DW-1:0] line [BEATS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"},  wvalid, 0);
    chk({tag, "_wlast"},   wlast, 0);
    chk({tag, "_bready"},  bready, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"},  rready, 0);
    chk({tag, "_valid_ld"}, valid_ld, 0);
    chk({tag, "_ready_wb"}, ready_wb, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
    chk({tag, "_awaddr"},  awaddr, 0);
    chk({tag, "_araddr"},  araddr, 0);
    chk({tag, "_wdata"},   wdata, 0);
    chk({tag, "_buffer"},  32'(|data_in_m), 0);
  endtask

  task automatic do_load(input logic [31:0] addr, input int ar_delay, input int err_beat,
                         input bit index_data, input bit gaps);
    logic [DW-1:0] exp_line [BEATS];
    logic [31:0]   exp_addr;
    int beat;
    int guard;
    int hold;
    exp_addr = addr - (addr % BEATS);
    addr_valid_out = 1'b1; addr_out_m = addr; rw_out = 1'b0;
    tick();
    addr_valid_out = 1'b0; addr_out_m = $urandom; rw_out = 1'($urandom);
    for (int c = 0; c < ar_delay; c++) begin
      arready = 1'b0;
      chk("ar_wait_arvalid", arvalid, 1);
      chk("ar_wait_araddr", araddr, exp_addr);
      chk("ar_wait_rready", rready, 0);
      tick();
    end
    arready = 1'b1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, exp_addr);
    chk("arlen", arlen, BEATS - 1);
    chk("arsize", arsize, 2);
    chk("arburst", arburst, 1);
    tick();
    arready = 1'b0;
    beat = 0; guard = 0;
    while (beat < BEATS && guard < 1000) begin
      rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdata  = index_data ? DW'(beat) : $urandom;
      rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
      rlast  = (beat == BEATS - 1);
      chk("rready", rready, 1);
      chk("r_valid_ld_low", valid_ld, 0);
      tick();
      if (rvalid) begin
        exp_line[beat] = rdata;
        if (rresp != 2'b00) err_model = 1'b1;
        beat++;
      end
      guard++;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    chk("r_beats", beat, BEATS);
    hold = $urandom_range(0, 3);
    for (int c = 0; c < hold; c++) begin
      ready_ld = 1'b0;
      chk("ld_hold_valid", valid_ld, 1);
      chk("ld_rready_low", rready, 0);
      tick();
    end
    chk("valid_ld", valid_ld, 1);
    for (int i = 0; i < BEATS; i++) chk("ld_word", data_in_m[i*DW +: DW], exp_line[i]);
    ready_ld = 1'b1;
    tick();
    ready_ld = 1'b0;
    chk("ld_done", valid_ld, 0);
    chk("ld_bus_err", bus_err, err_model);
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic [DW-1:0] wline [BEATS],
                       input bit rand_wready, input int b_delay, input logic [1:0] bresp_v,
                       input int abort_beat);
    logic [31:0] exp_addr;
    int pulses;
    int beat;
    int cyc;
    int aw_d;
    exp_addr = addr - (addr % BEATS);
    pulses = 0;
    addr_valid_out = 1'b1; addr_out_m = addr; rw_out = 1'b1;
    tick();
    addr_valid_out = 1'b0; addr_out_m = $urandom; rw_out = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      chk("wbcap_wait_ready_wb", ready_wb, 0);
      chk("wbcap_wait_awvalid", awvalid, 0);
      tick();
    end
    for (int i = 0; i < BEATS; i++) data_out_m[i*DW +: DW] = wline[i];
    valid_wb = 1'b1;
    #1;
    if (ready_wb) pulses++;
    tick();
    valid_wb = 1'b0; data_out_m = '1;
    aw_d = $urandom_range(0, 3);
    for (int c = 0; c < aw_d; c++) begin
      awready = 1'b0;
      if (ready_wb) pulses++;
      chk("aw_wait_awvalid", awvalid, 1);
      chk("aw_wait_awaddr", awaddr, exp_addr);
      chk("aw_wait_wvalid", wvalid, 0);
      tick();
    end
    awready = 1'b1;
    if (ready_wb) pulses++;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, exp_addr);
    chk("awlen", awlen, BEATS - 1);
    chk("awsize", awsize, 2);
    chk("awburst", awburst, 1);
    chk("wstrb", wstrb, 4'hF);
    tick();
    awready = 1'b0;
    chk("ready_wb_pulses", pulses, 1);
    beat = 0; cyc = 0;
    while (beat < BEATS && cyc < 1000) begin
      if (beat == abort_beat) break;
      wready = rand_wready ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, wline[beat]);
      chk("wlast", wlast, 32'(beat == BEATS - 1));
      tick();
      if (wready) beat++;
      cyc++;
    end
    wready = 1'b0;
    if (abort_beat >= 0) begin
      chk("w_abort_beat", beat, abort_beat);
      return;
    end
    chk("w_beats", beat, BEATS);
    for (int c = 0; c < b_delay; c++) begin
      bvalid = 1'b0;
      chk("b_wait_bready", bready, 1);
      chk("b_wait_wvalid", wvalid, 0);
      tick();
    end
    bvalid = 1'b1; bresp = bresp_v;
    chk("bready", bready, 1);
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    if (bresp_v != 2'b00) err_model = 1'b1;
    chk("b_done_bready", bready, 0);
    chk("wb_bus_err", bus_err, err_model);
  endtask

  initial begin
    addr_valid_out = 0; addr_out_m = 0; rw_out = 0; valid_wb = 0; data_out_m = '0;
    ready_ld = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    do_load(32'h0000_1234, 0, -1, 1'b1, 1'b0);
    do_load($urandom, 10, -1, 1'b0, 1'b1);

    for (int i = 0; i < BEATS; i++) line[i] = 32'hA000_0000 + i;
    do_wb(32'h0000_8040, line, 1'b0, 3, 2'b00, -1);

    for (int i = 0; i < BEATS; i++) line[i] = $urandom;
    do_wb($urandom, line, 1'b1, $urandom_range(0, 4), 2'b00, -1);

    do_load($urandom, 2, 5, 1'b0, 1'b1);
    do_load($urandom, 0, -1, 1'b0, 1'b0);
    for (int i = 0; i < BEATS; i++) line[i] = $urandom;
    do_wb($urandom, line, 1'b1, 1, 2'b00, -1);

    for (int i = 0; i < BEATS; i++) line[i] = $urandom;
    do_wb($urandom | 32'h0000_0100, line, 1'b1, 0, 2'b00, 20);
    #2;
    rst_n = 1'b0;
    #1;
    err_model = 1'b0;
    chk_idle_outputs("midburst_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    do_load($urandom, 1, -1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
